spi_pattern_matcher: RTL and testbench
======================================

// Module: spi_pattern_matcher
// PURPOSE
//  Parametrised byte-stream pattern matcher placed between spi_slave and the
//  top-level debug logic. Consumes received bytes via the spi_data_ready/spi_read_ack
//  level/ack handshake and compares them against a compile-time PATTERN.
//  Frame mode: compares bytes in one chip-select frame. Sliding mode: finds PATTERN
//  anywhere in the stream. Reports match/mismatch/overflow pulses and a saturating match count.
// PARAMETERS
//  DATA_WIDTH   8      bits per received word
//  PATTERN_LEN  16     words in PATTERN (>=2)
//  PATTERN      {"SPI debug data",8'h0D,8'h0A}  flat DATA_WIDTH*PATTERN_LEN; word 0 = MSB slice, first sent
//  SLIDING      0      0 = frame-aligned compare, 1 = sliding-window search
//  COUNT_WIDTH  16     width of match_count
// PORTS
//  system_clk     in   1              system clock (27 MHz)
//  reset          in   1              asynchronous, active-high reset
//  rx_data        in   DATA_WIDTH     received word, stable while rx_valid high
//  rx_valid       in   1              level: word available (spi_data_ready)
//  rx_ack         out  1              one-cycle acknowledge (to spi_read_ack)
//  frame_active   in   1              high while CS asserted (synchronised upstream)
//  match_pulse    out  1              one-cycle pulse: PATTERN matched
//  mismatch_pulse out  1              one-cycle pulse: frame compare failed (frame mode only)
//  overflow_pulse out  1              one-cycle pulse: word beyond PATTERN_LEN in frame (frame mode only)
//  match_count    out  COUNT_WIDTH    saturating count of match_pulse events
//  word_index     out  clog2(PATTERN_LEN+1)  words accepted in current frame, saturates at PATTERN_LEN
// BEHAVIOUR
//  - Reset: every output 0, FSM=IDLE, index/window/sticky-error cleared. Any in-flight word is dropped and not acked.
//  - FSM states: IDLE (accept on rx_valid) -> ACK (rx_ack=1 for exactly one cycle) ->
//    WAIT_DROP (hold until rx_valid=0) -> IDLE. A held-high rx_valid is never re-accepted.
//  - Accept at cycle N. At N+1: rx_ack=1, and any match/mismatch/overflow pulse for that word is also 1.
//    The compare is combinational against the incoming word and registered, so both modes have the same latency.
//  - A word accepted while frame_active=0 is acked and then discarded. It changes no state.
//  - Frame mode: compare rx_data with PATTERN[word_index]; any difference sets the sticky error.
//    At the PATTERN_LEN-th word, emit match_pulse if there is no error, otherwise mismatch_pulse. The result is then marked done.
//    Further words in the same frame: overflow_pulse for each, no new match/mismatch.
//  - Frame end (frame_active 1->0): if 0<word_index<PATTERN_LEN and no result yet, mismatch_pulse one cycle after the fall.
//    Then clear index, error and done. A word accepted in the same cycle as the fall belongs to the closing frame.
//  - Sliding mode: a PATTERN_LEN-deep shift window plus a fill counter; fill clears on frame end.
//    match_pulse when fill>=PATTERN_LEN (counting the new word) and window==PATTERN. Overlapping matches all count.
//    mismatch_pulse and overflow_pulse stay 0.
//  - match_count increments on each match_pulse and saturates at all-ones (no wrap).
//  - Width rules: index compare uses unsigned arithmetic; PATTERN slice = PATTERN[DATA_WIDTH*(PATTERN_LEN-i)-1 -: DATA_WIDTH].
//  - Reset asserted mid-frame: immediate clear. After release, wait for frame_active to go low before counting
//    (a partial frame after reset is ignored).
// STRUCTURE
//  - Shared package spi_match_pkg: FSM state typedef (IDLE/ACK/WAIT_DROP), clog2 helper function,
//    default PATTERN constant.
//  - One sub-module: match_window (shift register, fill counter, full-window compare). Instantiated only when SLIDING=1.
//  - Top body: handshake FSM, frame-mode index/error logic, frame-edge detector, count saturator.
// TESTING
//  1 Frame mode: 16 words "SPI debug data\r\n" in one frame -> match_pulse one cycle after 16th accept; match_count=1; 16 rx_ack pulses.
//  2 Same frame with word 5 = 'x' -> mismatch_pulse after 16th accept; match_count unchanged; no match_pulse.
//  3 10-word frame then frame_active low -> mismatch_pulse one cycle after the fall; next full correct frame -> match_pulse, word_index restarts at 0.
//  4 17-word frame with correct first 16 -> match at 16th, overflow_pulse at 17th; word_index holds 16.
//  5 SLIDING=1, COUNT_WIDTH=2: "xx"+pattern+pattern+pattern+pattern in one frame -> match after words 18,34,50,66; match_count saturates at 3.
//  6 reset pulse after 8 words mid-frame -> all outputs 0, no rx_ack for pending word; after release, new frame with full pattern -> match, count=1.

Source files
------------

// File: rtl/spi_match_pkg.sv
// rtl/spi_match_pkg.sv - shared types, constants and helpers for spi_pattern_matcher
//
// Contents:
//   state_t          handshake FSM states (IDLE / ACK / WAIT_DROP)
//   DEFAULT_PATTERN  "SPI debug data\r\n", word 0 in the MSB slice
//   clog2            ceiling log2, usable in constant expressions
package spi_match_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  localparam logic [127:0] DEFAULT_PATTERN = {"SPI debug data", 8'h0D, 8'h0A};

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_pattern_matcher_if.sv
// rtl/spi_pattern_matcher_if.sv - receive handshake between spi_slave and the pattern matcher
//
// Signals:
//   rx_data       received word, stable while rx_valid is high
//   rx_valid      level: a word is available
//   rx_ack        one-cycle acknowledge back to the SPI slave
//   frame_active  high while chip select is asserted
// Modports:
//   master  SPI slave side (drives data/valid/frame, sees ack)
//   slave   matcher side
interface spi_pattern_matcher_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ack;
  logic                  frame_active;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_active,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_active,
    output rx_ack
  );

endinterface

// File: rtl/match_window.sv
// rtl/match_window.sv - sliding-window compare of the last PATTERN_LEN words against PATTERN
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   shift_en  a word is being taken into the window this cycle
//   clear     frame ended: forget the window fill
//   data      incoming word
//   hit       combinational: window including the incoming word equals PATTERN
module match_window
  import spi_match_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PATTERN_LEN = 16,
  parameter logic [DATA_WIDTH*PATTERN_LEN-1:0] PATTERN = DEFAULT_PATTERN,
  localparam int FILL_WIDTH = clog2(PATTERN_LEN + 1),
  localparam int HIST_WIDTH = DATA_WIDTH * (PATTERN_LEN - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  hit
);

  // Only the previous PATTERN_LEN-1 words are stored; the incoming word
  // completes the window so a match is reported in the same cycle it arrives.
  logic [HIST_WIDTH-1:0]             history;
  logic [DATA_WIDTH*PATTERN_LEN-1:0] window;
  logic [FILL_WIDTH-1:0]             fill;

  assign window = {history, data};
  assign hit    = (fill >= FILL_WIDTH'(PATTERN_LEN - 1)) && (window == PATTERN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
    end else begin
      if (shift_en) begin
        history <= window[HIST_WIDTH-1:0];
      end
      // A word taken on the closing edge still counts, but the next frame
      // starts from an empty window.
      if (clear) begin
        fill <= '0;
      end else if (shift_en && fill != FILL_WIDTH'(PATTERN_LEN)) begin
        fill <= fill + FILL_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/spi_pattern_matcher.sv
// rtl/spi_pattern_matcher.sv - byte-stream pattern matcher behind the SPI slave
//
// Takes words over a level/ack handshake and compares them with PATTERN,
// frame-aligned (SLIDING=0) or anywhere in the stream (SLIDING=1).
//
// Ports:
//   system_clk      system clock
//   reset           asynchronous active-high reset
//   rx              slave side of the receive handshake
//   match_pulse     one-cycle pulse: PATTERN matched
//   mismatch_pulse  one-cycle pulse: frame compare failed (frame mode)
//   overflow_pulse  one-cycle pulse per word past PATTERN_LEN (frame mode)
//   match_count     saturating count of match pulses
//   word_index      words accepted in current frame, saturates at PATTERN_LEN
module spi_pattern_matcher
  import spi_match_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PATTERN_LEN = 16,
  parameter logic [DATA_WIDTH*PATTERN_LEN-1:0] PATTERN = DEFAULT_PATTERN,
  parameter bit SLIDING = 1'b0,
  parameter int COUNT_WIDTH = 16,
  localparam int INDEX_WIDTH = clog2(PATTERN_LEN + 1)
) (
  input  logic                    system_clk,
  input  logic                    reset,
  spi_pattern_matcher_if.slave    rx,
  output logic                    match_pulse,
  output logic                    mismatch_pulse,
  output logic                    overflow_pulse,
  output logic [COUNT_WIDTH-1:0]  match_count,
  output logic [INDEX_WIDTH-1:0]  word_index
);

  localparam int SEL_WIDTH = clog2(PATTERN_LEN);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(PATTERN_LEN);

  state_t state;
  state_t state_next;

  logic frame_prev;
  logic armed;
  logic error;
  logic accept;
  logic take;
  logic frame_fall;
  logic at_end;
  logic word_error;
  logic window_hit;
  logic [SEL_WIDTH-1:0]   select;
  logic [INDEX_WIDTH-1:0] index_next;
  logic                   error_next;
  logic                   match_next;
  logic                   mismatch_next;
  logic                   overflow_next;

  logic [DATA_WIDTH-1:0] pattern_word [PATTERN_LEN];

  for (genvar i = 0; i < PATTERN_LEN; i++) begin : g_pattern_word
    assign pattern_word[i] = PATTERN[DATA_WIDTH*(PATTERN_LEN-i)-1 -: DATA_WIDTH];
  end

  // Handshake FSM: a word is taken once per rx_valid high period.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rx.rx_ack  = 1'b0;
    case (state)
      IDLE:      if (rx.rx_valid) state_next = ACK;
      ACK: begin
        rx.rx_ack  = 1'b1;
        state_next = WAIT_DROP;
      end
      WAIT_DROP: if (!rx.rx_valid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && rx.rx_valid;
  assign frame_fall = frame_prev && !rx.frame_active;
  // frame_prev keeps a word arriving on the falling edge inside its frame.
  // armed stays low after reset until frame_active has been seen low, so a
  // frame already in progress at reset release is ignored.
  assign take       = accept && armed && (rx.frame_active || frame_prev);
  assign at_end     = (word_index == LAST_INDEX);
  assign select     = at_end ? '0 : word_index[SEL_WIDTH-1:0];
  assign word_error = (rx.rx_data != pattern_word[select]);

  if (SLIDING) begin : g_window
    match_window #(
      .DATA_WIDTH  (DATA_WIDTH),
      .PATTERN_LEN (PATTERN_LEN),
      .PATTERN     (PATTERN)
    ) u_match_window (
      .clk      (system_clk),
      .rst      (reset),
      .shift_en (take),
      .clear    (frame_fall),
      .data     (rx.rx_data),
      .hit      (window_hit)
    );
  end else begin : g_no_window
    assign window_hit = 1'b0;
  end

  always_comb begin
    index_next    = word_index;
    error_next    = error;
    match_next    = 1'b0;
    mismatch_next = 1'b0;
    overflow_next = 1'b0;
    if (take) begin
      if (at_end) begin
        overflow_next = !SLIDING;
      end else begin
        index_next = word_index + INDEX_WIDTH'(1);
        error_next = error | word_error;
        if (index_next == LAST_INDEX) begin
          match_next    = !SLIDING && !error_next;
          mismatch_next = !SLIDING && error_next;
        end
      end
      if (SLIDING) begin
        match_next = window_hit;
      end
    end
    // Short frame: it ended before a result was produced. The word taken on
    // the same edge has already been folded into index_next.
    if (frame_fall && !SLIDING && index_next != '0 && index_next != LAST_INDEX) begin
      mismatch_next = 1'b1;
    end
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      frame_prev     <= 1'b0;
      armed          <= 1'b0;
      error          <= 1'b0;
      word_index     <= '0;
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      overflow_pulse <= 1'b0;
      match_count    <= '0;
    end else begin
      frame_prev     <= rx.frame_active;
      armed          <= armed | !rx.frame_active;
      match_pulse    <= match_next;
      mismatch_pulse <= mismatch_next;
      overflow_pulse <= overflow_next;
      if (frame_fall) begin
        word_index <= '0;
        error      <= 1'b0;
      end else begin
        word_index <= index_next;
        error      <= error_next;
      end
      if (match_next && match_count != '1) begin
        match_count <= match_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_pattern_matcher.sv
// tb/tb_spi_pattern_matcher.sv - randomized self-checking bench for spi_pattern_matcher
module tb_spi_pattern_matcher;

  localparam int LEN = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_pattern_matcher_if #(.DATA_WIDTH(8)) bus_f ();
  spi_pattern_matcher_if #(.DATA_WIDTH(8)) bus_s ();

  assign bus_s.rx_data      = bus_f.rx_data;
  assign bus_s.rx_valid     = bus_f.rx_valid;
  assign bus_s.frame_active = bus_f.frame_active;

  logic        match_f, mismatch_f, overflow_f;
  logic [15:0] count_f;
  logic [4:0]  index_f;
  logic        match_s, mismatch_s, overflow_s;
  logic [1:0]  count_s;
  logic [4:0]  index_s;

  spi_pattern_matcher dut_f (
    .system_clk     (clk),
    .reset          (rst),
    .rx             (bus_f),
    .match_pulse    (match_f),
    .mismatch_pulse (mismatch_f),
    .overflow_pulse (overflow_f),
    .match_count    (count_f),
    .word_index     (index_f)
  );

  spi_pattern_matcher #(.SLIDING(1'b1), .COUNT_WIDTH(2)) dut_s (
    .system_clk     (clk),
    .reset          (rst),
    .rx             (bus_s),
    .match_pulse    (match_s),
    .mismatch_pulse (mismatch_s),
    .overflow_pulse (overflow_s),
    .match_count    (count_s),
    .word_index     (index_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: words of the current frame, arming state, expected counts.
  logic [7:0] pat [LEN];
  logic [7:0] q [$];
  bit armed_m;
  int cnt_f, cnt_s;
  int tot_ack, tot_match_f, tot_mis_f, tot_ovf_f, tot_match_s;
  int mon_ack_f, mon_ack_s, mon_match_f, mon_mis_f, mon_ovf_f, mon_match_s, mon_other_s;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon_ack_f   += int'(bus_f.rx_ack);
      mon_ack_s   += int'(bus_s.rx_ack);
      mon_match_f += int'(match_f);
      mon_mis_f   += int'(mismatch_f);
      mon_ovf_f   += int'(overflow_f);
      mon_match_s += int'(match_s);
      mon_other_s += int'(mismatch_s | overflow_s);
    end
  end

  task automatic note_results(input bit m_f, input bit mm_f, input bit ov_f, input bit m_s);
    if (m_f && cnt_f < 65535) cnt_f++;
    if (m_s && cnt_s < 3) cnt_s++;
    tot_match_f += int'(m_f);
    tot_mis_f   += int'(mm_f);
    tot_ovf_f   += int'(ov_f);
    tot_match_s += int'(m_s);
  endtask

  task automatic check_outputs(input string where, input bit m_f, input bit mm_f,
                               input bit ov_f, input bit m_s);
    int exp_idx;
    exp_idx = (q.size() < LEN) ? q.size() : LEN;
    check_eq({where, "/match_f"}, match_f, m_f);
    check_eq({where, "/mismatch_f"}, mismatch_f, mm_f);
    check_eq({where, "/overflow_f"}, overflow_f, ov_f);
    check_eq({where, "/count_f"}, count_f, cnt_f);
    check_eq({where, "/index_f"}, index_f, exp_idx);
    check_eq({where, "/match_s"}, match_s, m_s);
    check_eq({where, "/mismatch_s"}, mismatch_s, 0);
    check_eq({where, "/overflow_s"}, overflow_s, 0);
    check_eq({where, "/count_s"}, count_s, cnt_s);
    check_eq({where, "/index_s"}, index_s, exp_idx);
  endtask

  task automatic send_word(input logic [7:0] d, input bit close);
    bit in_frame, seen, ok, m_f, mm_f, ov_f, m_s;
    int n;
    in_frame = bus_f.frame_active;
    bus_f.rx_data  = d;
    bus_f.rx_valid = 1'b1;
    if (close) bus_f.frame_active = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      seen = bus_f.rx_ack;
    end
    check_eq("ack_f_seen", seen, 1);
    check_eq("ack_s", bus_s.rx_ack, 1);
    tot_ack++;
    m_f = 0; mm_f = 0; ov_f = 0; m_s = 0;
    if (in_frame && armed_m) begin
      q.push_back(d);
      n = q.size();
      if (n == LEN) begin
        ok = 1;
        for (int i = 0; i < LEN; i++) if (q[i] !== pat[i]) ok = 0;
        m_f  = ok;
        mm_f = !ok;
      end
      if (n > LEN) ov_f = 1;
      if (n >= LEN) begin
        ok = 1;
        for (int i = 0; i < LEN; i++) if (q[n-LEN+i] !== pat[i]) ok = 0;
        m_s = ok;
      end
    end
    if (close && in_frame) begin
      if (armed_m && q.size() > 0 && q.size() < LEN) mm_f = 1;
      q.delete();
    end
    if (close || !in_frame) armed_m = 1;
    note_results(m_f, mm_f, ov_f, m_s);
    check_outputs("word", m_f, mm_f, ov_f, m_s);
    bus_f.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic close_frame();
    bit mm_f;
    mm_f = armed_m && q.size() > 0 && q.size() < LEN;
    bus_f.frame_active = 1'b0;
    @(negedge clk);
    q.delete();
    armed_m = 1;
    note_results(0, mm_f, 0, 0);
    check_outputs("close", 0, mm_f, 0, 0);
    @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    armed_m = 1;
    bus_f.frame_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_list(input logic [7:0] w [$], input bit close_last);
    for (int i = 0; i < w.size(); i++) begin
      send_word(w[i], close_last && (i == w.size() - 1));
    end
  endtask

  task automatic do_reset();
    bus_f.rx_data  = 8'($urandom_range(0, 255));
    bus_f.rx_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst/ack_f", bus_f.rx_ack, 0);
    check_eq("rst/ack_s", bus_s.rx_ack, 0);
    check_eq("rst/pulses_f", {match_f, mismatch_f, overflow_f}, 0);
    check_eq("rst/pulses_s", {match_s, mismatch_s, overflow_s}, 0);
    check_eq("rst/count_f", count_f, 0);
    check_eq("rst/count_s", count_s, 0);
    check_eq("rst/index_f", index_f, 0);
    check_eq("rst/index_s", index_s, 0);
    bus_f.rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    armed_m = 0;
    cnt_f = 0;
    cnt_s = 0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    logic [7:0] w [$];
    s = "SPI debug data\r\n";
    for (int i = 0; i < LEN; i++) pat[i] = s[i];

    rst = 1'b1;
    bus_f.rx_data      = 8'h00;
    bus_f.rx_valid     = 1'b0;
    bus_f.frame_active = 1'b0;
    do_reset();

    // full correct frame
    w.delete();
    for (int i = 0; i < LEN; i++) w.push_back(pat[i]);
    start_frame(); send_list(w, 0); close_frame();

    // word 5 corrupted
    w[5] = 8'h78;
    start_frame(); send_list(w, 0); close_frame();

    // 10-word short frame, then a correct frame
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back(pat[i]);
    start_frame(); send_list(w, 0); close_frame();
    w.delete();
    for (int i = 0; i < LEN; i++) w.push_back(pat[i]);
    start_frame(); send_list(w, 0); close_frame();

    // 17 words: match at 16th, overflow at 17th
    w.push_back(8'h5A);
    start_frame(); send_list(w, 0); close_frame();

    // "xx" + four patterns: overlapping sliding matches, 2-bit count saturates
    w.delete();
    w.push_back(8'h78); w.push_back(8'h78);
    for (int r = 0; r < 4; r++) for (int i = 0; i < LEN; i++) w.push_back(pat[i]);
    start_frame(); send_list(w, 0); close_frame();

    // last word arrives on the falling edge of the frame
    w.delete();
    for (int i = 0; i < LEN; i++) w.push_back(pat[i]);
    start_frame(); send_list(w, 1);

    // reset mid-frame, partial frame after release is ignored
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back(pat[i]);
    start_frame(); send_list(w, 0);
    do_reset();
    w.delete();
    for (int i = 8; i < 11; i++) w.push_back(pat[i]);
    send_list(w, 0); close_frame();
    w.delete();
    for (int i = 0; i < LEN; i++) w.push_back(pat[i]);
    start_frame(); send_list(w, 0); close_frame();

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int kind, len, bad, off;
      bit close_last;
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 40);
      bad  = $urandom_range(0, len - 1);
      off  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      close_last = $urandom_range(0, 1) == 1;
      w.delete();
      for (int i = 0; i < len; i++) begin
        case (kind)
          0: w.push_back(pat[(i + off) % LEN]);
          1: w.push_back((i == bad) ? (pat[(i + off) % LEN] ^ 8'h01) : pat[(i + off) % LEN]);
          2: w.push_back(pat[$urandom_range(0, LEN - 1)]);
          default: w.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      start_frame();
      send_list(w, close_last);
      if (!close_last) close_frame();
      if ($urandom_range(0, 4) == 0) send_word(8'($urandom_range(0, 255)), 0);
    end

    repeat (3) @(negedge clk);
    check_eq("total/ack_f", mon_ack_f, tot_ack);
    check_eq("total/ack_s", mon_ack_s, tot_ack);
    check_eq("total/match_f", mon_match_f, tot_match_f);
    check_eq("total/mismatch_f", mon_mis_f, tot_mis_f);
    check_eq("total/overflow_f", mon_ovf_f, tot_ovf_f);
    check_eq("total/match_s", mon_match_s, tot_match_s);
    check_eq("total/other_s", mon_other_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
